// File: rtl/dd_incoming_pipe.sv
// rtl/dd_incoming_pipe.sv - two-stage cumulative/selective ack pipeline for an incoming flow window
//
// Purpose: takes one ack packet per cycle (a cumulative ack plus up to NUM_SACK
// selective acks) together with the flow's current window context. It produces the
// advanced window context, the merged acked bitmap and the counts of newly
// acknowledged slots. Stage 1 advances the window and counts cumulative acks.
// Stage 2 qualifies and merges the selective acks and holds the outputs.
//
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   in_valid / in_ready             input handshake
//   cumulative_ack_in               cumulative ack sequence number
//   sack_in, sack_val_in            selective acks (slot k at [k*W +: W]) and present flags
//   acked_wnd_in                    per-slot acked bitmap of the current window
//   wnd_start_ind_in, wnd_start_in  window start bitmap index / sequence number
//   wnd_size_in                     window size in slots (at most FLOW_WIN_SIZE-1)
//   out_valid / out_ready           output handshake
//   valid_sack_out                  per-slot selective ack accepted flag
//   new_c_acks_cnt, new_s_acks_cnt  newly acked slots by cumulative / selective ack
//   ack_err_out                     cumulative ack beyond the window end
//   acked_wnd_out, wnd_start_ind_out, wnd_start_out   updated window context

module dd_incoming_pipe #(
    parameter int FLOW_WIN_SIZE  = 128,
    parameter int FLOW_WIN_IND_W = 8,
    parameter int FLOW_SEQ_NUM_W = 32,
    parameter int NUM_SACK       = 2
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [FLOW_SEQ_NUM_W-1:0]          cumulative_ack_in,
    input  logic [NUM_SACK*FLOW_SEQ_NUM_W-1:0] sack_in,
    input  logic [NUM_SACK-1:0]                sack_val_in,
    input  logic [FLOW_WIN_SIZE-1:0]           acked_wnd_in,
    input  logic [FLOW_WIN_IND_W-1:0]          wnd_start_ind_in,
    input  logic [FLOW_SEQ_NUM_W-1:0]          wnd_start_in,
    input  logic [FLOW_WIN_IND_W-1:0]          wnd_size_in,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [NUM_SACK-1:0]                valid_sack_out,
    output logic [FLOW_WIN_IND_W-1:0]          new_c_acks_cnt,
    output logic [FLOW_WIN_IND_W-1:0]          new_s_acks_cnt,
    output logic                               ack_err_out,
    output logic [FLOW_WIN_SIZE-1:0]           acked_wnd_out,
    output logic [FLOW_WIN_IND_W-1:0]          wnd_start_ind_out,
    output logic [FLOW_SEQ_NUM_W-1:0]          wnd_start_out
);

    localparam int LW = FLOW_WIN_IND_W - 1;
    localparam int SW = FLOW_SEQ_NUM_W;
    localparam int IW = FLOW_WIN_IND_W;

    typedef logic [LW-1:0] idx_t;

    // ------------------------------------------------------------------
    // Flow control
    // ------------------------------------------------------------------
    logic s1_valid_q;
    logic s2_valid_q;
    logic s1_advance;

    // Stage 1 may hand its packet on whenever stage 2 is empty or being drained.
    assign s1_advance = !s2_valid_q || out_ready;
    // Gated by rst_n so nothing is accepted while reset is held.
    assign in_ready   = rst_n && (!s1_valid_q || s1_advance);
    assign out_valid  = s2_valid_q;

    // ------------------------------------------------------------------
    // Stage 1: window advance, window mask, cumulative-ack count
    // ------------------------------------------------------------------
    idx_t                ind_in_lo;
    logic [SW-1:0]       size_in_ext;
    logic                s1_err_d;
    logic [SW-1:0]       s1_ws_out_d;
    idx_t                s1_ind_out_d;
    idx_t                s1_new_len;
    logic [FLOW_WIN_SIZE-1:0] s1_win_mask_d;
    logic [IW-1:0]       s1_c_cnt_d;
    idx_t                s1_idx_bias_d;

    logic                s1_err_q;
    logic [SW-1:0]       s1_ws_out_q;
    idx_t                s1_ind_out_q;
    logic [FLOW_WIN_SIZE-1:0] s1_win_mask_q;
    logic [IW-1:0]       s1_c_cnt_q;
    logic [IW-1:0]       s1_size_q;
    idx_t                s1_idx_bias_q;
    logic [FLOW_WIN_SIZE-1:0] s1_acked_q;
    logic [NUM_SACK*SW-1:0]   s1_sack_q;
    logic [NUM_SACK-1:0] s1_sack_val_q;

    // The index MSB is always zero by construction; it is never needed.
    logic unused_ind_msb;
    assign unused_ind_msb = wnd_start_ind_in[FLOW_WIN_IND_W-1];

    assign ind_in_lo   = wnd_start_ind_in[LW-1:0];
    assign size_in_ext = SW'(wnd_size_in);

    always_comb begin
        s1_err_d    = cumulative_ack_in > (wnd_start_in + size_in_ext);
        s1_ws_out_d = wnd_start_in;
        if (!s1_err_d && (cumulative_ack_in > wnd_start_in)) begin
            s1_ws_out_d = cumulative_ack_in;
        end
        // On error or a stale ack the start does not move, so the index stays put
        // and the newly-acked span collapses to zero length.
        s1_ind_out_d  = ind_in_lo + s1_ws_out_d[LW-1:0] - wnd_start_in[LW-1:0];
        s1_new_len    = s1_ind_out_d - ind_in_lo;
        // Folding (ind - start) here lets stage 2 map a sack to its slot with one add.
        s1_idx_bias_d = ind_in_lo - wnd_start_in[LW-1:0];
        s1_win_mask_d = '0;
        s1_c_cnt_d    = '0;
        for (int i = 0; i < FLOW_WIN_SIZE; i++) begin
            // Distance of slot i from the region start, modulo the window size,
            // handles wrap through index 0 for both masks.
            s1_win_mask_d[i] = {1'b0, idx_t'(idx_t'(i) - s1_ind_out_d)} < wnd_size_in;
            if (((idx_t'(i) - ind_in_lo) < s1_new_len) && !acked_wnd_in[i]) begin
                s1_c_cnt_d = s1_c_cnt_d + IW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q    <= 1'b0;
            s1_err_q      <= 1'b0;
            s1_ws_out_q   <= '0;
            s1_ind_out_q  <= '0;
            s1_win_mask_q <= '0;
            s1_c_cnt_q    <= '0;
            s1_size_q     <= '0;
            s1_idx_bias_q <= '0;
            s1_acked_q    <= '0;
            s1_sack_q     <= '0;
            s1_sack_val_q <= '0;
        end else begin
            if (in_ready) begin
                s1_valid_q <= in_valid;
            end
            if (in_ready && in_valid) begin
                s1_err_q      <= s1_err_d;
                s1_ws_out_q   <= s1_ws_out_d;
                s1_ind_out_q  <= s1_ind_out_d;
                s1_win_mask_q <= s1_win_mask_d;
                s1_c_cnt_q    <= s1_c_cnt_d;
                s1_size_q     <= wnd_size_in;
                s1_idx_bias_q <= s1_idx_bias_d;
                s1_acked_q    <= acked_wnd_in;
                s1_sack_q     <= sack_in;
                s1_sack_val_q <= sack_val_in;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: selective ack qualification and merge
    // ------------------------------------------------------------------
    logic [SW-1:0]       sack_seq [NUM_SACK];
    idx_t                sack_idx [NUM_SACK];
    logic [SW-1:0]       s1_win_end;
    logic [NUM_SACK-1:0] s2_vs_d;
    logic [FLOW_WIN_SIZE-1:0] s2_hit;
    logic [IW-1:0]       s2_s_cnt_d;
    logic [FLOW_WIN_SIZE-1:0] s2_acked_d;

    logic [NUM_SACK-1:0] s2_vs_q;
    logic [IW-1:0]       s2_c_cnt_q;
    logic [IW-1:0]       s2_s_cnt_q;
    logic                s2_err_q;
    logic [FLOW_WIN_SIZE-1:0] s2_acked_q;
    idx_t                s2_ind_q;
    logic [SW-1:0]       s2_ws_q;

    for (genvar k = 0; k < NUM_SACK; k++) begin : g_sack
        assign sack_seq[k] = s1_sack_q[k*SW +: SW];
        assign sack_idx[k] = sack_seq[k][LW-1:0] + s1_idx_bias_q;
    end

    assign s1_win_end = s1_ws_out_q + SW'(s1_size_q);

    always_comb begin
        s2_vs_d    = '0;
        s2_hit     = '0;
        s2_s_cnt_d = '0;
        for (int k = 0; k < NUM_SACK; k++) begin
            s2_vs_d[k] = !s1_err_q && s1_sack_val_q[k]
                         && (sack_seq[k] > s1_ws_out_q) && (sack_seq[k] < s1_win_end)
                         && !s1_acked_q[sack_idx[k]];
            // A repeat of an already accepted lower slot is not counted twice.
            for (int j = 0; j < k; j++) begin
                if (s2_vs_d[j] && (sack_seq[j] == sack_seq[k])) begin
                    s2_vs_d[k] = 1'b0;
                end
            end
            if (s2_vs_d[k]) begin
                s2_hit[sack_idx[k]] = 1'b1;
                s2_s_cnt_d          = s2_s_cnt_d + IW'(1);
            end
        end
        // An erroneous packet leaves the bitmap exactly as it arrived.
        s2_acked_d = s1_err_q ? s1_acked_q : (s1_win_mask_q & (s1_acked_q | s2_hit));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_valid_q <= 1'b0;
            s2_vs_q    <= '0;
            s2_c_cnt_q <= '0;
            s2_s_cnt_q <= '0;
            s2_err_q   <= 1'b0;
            s2_acked_q <= '0;
            s2_ind_q   <= '0;
            s2_ws_q    <= '0;
        end else if (s1_advance) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_vs_q    <= s2_vs_d;
                s2_c_cnt_q <= s1_c_cnt_q;
                s2_s_cnt_q <= s2_s_cnt_d;
                s2_err_q   <= s1_err_q;
                s2_acked_q <= s2_acked_d;
                s2_ind_q   <= s1_ind_out_q;
                s2_ws_q    <= s1_ws_out_q;
            end
        end
    end

    assign valid_sack_out    = s2_vs_q;
    assign new_c_acks_cnt    = s2_c_cnt_q;
    assign new_s_acks_cnt    = s2_s_cnt_q;
    assign ack_err_out       = s2_err_q;
    assign acked_wnd_out     = s2_acked_q;
    assign wnd_start_ind_out = {1'b0, s2_ind_q};
    assign wnd_start_out     = s2_ws_q;

endmodule
